mem_rw_stage: RTL and testbench

//  Storage stage fed by the bus-side interface: accepts write_en/read_en/address/data_in, holds a

---
 rtl/mem_pkg.sv | 18 +
 rtl/mem_rd_pipe.sv | 49 ++++
 rtl/mem_rw_stage.sv | 101 ++++++++++
 tb/tb_mem_rw_stage.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and default widths for the memory read/write stage.
//   DEF_DATA_WIDTH / DEF_ADDRESS_WIDTH : default widths for the stage
//   data_t, addr_t, cnt_t              : default-width data, address and occupancy types
//   rd_pipe_t                          : one read-pipeline slot {valid, miss, data}
package mem_pkg;
  localparam int DEF_DATA_WIDTH    = 32;
  localparam int DEF_ADDRESS_WIDTH = 4;

  typedef logic [DEF_DATA_WIDTH-1:0]    data_t;
  typedef logic [DEF_ADDRESS_WIDTH-1:0] addr_t;
  typedef logic [DEF_ADDRESS_WIDTH:0]   cnt_t;

  typedef struct packed {
    logic  valid;
    logic  miss;
    data_t data;
  } rd_pipe_t;
endpackage

// File: rtl/mem_rd_pipe.sv
// Read-return pipeline: STAGES-deep shift of {valid, miss, data} with an
// asynchronous active-low flush. Each stage's data only loads when the slot
// entering it is valid, so the final stage keeps showing the last returned
// value between pulses; miss is forced low on empty slots.
//   clk, rst            : clock, async active-low flush
//   in_valid/miss/data  : read accepted this edge and its snapshot
//   out_valid/miss/data : pipeline output, STAGES edges later
module mem_rd_pipe
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int STAGES     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  in_miss,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic                  out_miss,
  output logic [DATA_WIDTH-1:0] out_data
);

  logic [STAGES-1:0]                 vld_pipe;
  logic [STAGES-1:0]                 miss_pipe;
  logic [STAGES-1:0][DATA_WIDTH-1:0] data_pipe;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe  <= '0;
      miss_pipe <= '0;
      data_pipe <= '0;
    end else begin
      vld_pipe[0]  <= in_valid;
      miss_pipe[0] <= in_valid & in_miss;
      if (in_valid) data_pipe[0] <= in_data;
      for (int i = 1; i < STAGES; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        miss_pipe[i] <= vld_pipe[i-1] & miss_pipe[i-1];
        if (vld_pipe[i-1]) data_pipe[i] <= data_pipe[i-1];
      end
    end
  end

  assign out_valid = vld_pipe[STAGES-1];
  assign out_miss  = miss_pipe[STAGES-1];
  assign out_data  = data_pipe[STAGES-1];

endmodule

// File: rtl/mem_rw_stage.sv
// Storage stage: DEPTH x DATA_WIDTH array with per-entry written bits, an
// occupancy counter and a fixed-latency read return.
//   clk, rst   : clock, async active-low reset
//   clr        : sync clear of written bits and occ_count
//   write_en   : write data_in to address
//   read_en    : read address; returns READ_LATENCY edges later
//   address    : entry index shared by read and write
//   data_in    : write data
//   valid_out  : one-cycle pulse per accepted read
//   data_out   : read data (holds last value between pulses)
//   rd_miss    : with valid_out, entry had never been written
//   occ_count  : number of entries with their written bit set
module mem_rw_stage
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int READ_LATENCY  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     write_en,
  input  logic                     read_en,
  input  logic [ADDRESS_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0]    data_in,
  output logic                     valid_out,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     rd_miss,
  output logic [ADDRESS_WIDTH:0]   occ_count
);

  localparam int DEPTH = 1 << ADDRESS_WIDTH;
  localparam int CW    = ADDRESS_WIDTH + 1;

  generate
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
      $error("mem_rw_stage: READ_LATENCY must be 1 or 2");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0]      written;
  logic [DEPTH-1:0]      written_nxt;
  logic                  first_write;
  logic                  rd_miss_now;
  logic [DATA_WIDTH-1:0] rd_data_now;

  // Array contents are deliberately not reset; the written bits gate them.
  always_ff @(posedge clk) begin
    if (write_en) mem[address] <= data_in;
  end

  // Read snapshot sees pre-edge state, except a same-edge write which wins.
  always_comb begin
    rd_miss_now = !(write_en || written[address]);
    rd_data_now = '0;
    if (write_en)              rd_data_now = data_in;
    else if (written[address]) rd_data_now = mem[address];
  end

  assign first_write = write_en & ~written[address];

  // clr wipes everything except an entry written on the same edge.
  always_comb begin
    written_nxt = clr ? '0 : written;
    if (write_en) written_nxt[address] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      written   <= '0;
      occ_count <= '0;
    end else begin
      written <= written_nxt;
      if (clr) occ_count <= CW'(write_en);
      else     occ_count <= occ_count + CW'(first_write);
    end
  end

  mem_rd_pipe #(
    .DATA_WIDTH(DATA_WIDTH),
    .STAGES    (READ_LATENCY)
  ) u_rd_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_valid (read_en),
    .in_miss  (rd_miss_now),
    .in_data  (rd_data_now),
    .out_valid(valid_out),
    .out_miss (rd_miss),
    .out_data (data_out)
  );

`ifndef SYNTHESIS
  a_ctrl_known: assert property (@(posedge clk) disable iff (!rst)
    !$isunknown({write_en, read_en}))
    else $error("mem_rw_stage: X on write_en/read_en");
`endif

endmodule

// File: tb/tb_mem_rw_stage.sv
// Bench for mem_rw_stage: one instance at READ_LATENCY=1 and one at 2, driven
// by identical stimulus. A reference model (arrays + per-instance queues of
// expected returns) checks every cycle; a vector table and directed sequences
// add hand-computed expectations.
module tb_mem_rw_stage;

  logic        clk, rst, clr, we, re;
  logic [3:0]  addr;
  logic [31:0] din;
  logic        vo  [2];
  logic [31:0] dob [2];
  logic        mo  [2];
  logic [4:0]  oc  [2];

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  mem_rw_stage #(.DATA_WIDTH(32), .ADDRESS_WIDTH(4), .READ_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .clr(clr), .write_en(we), .read_en(re), .address(addr),
    .data_in(din), .valid_out(vo[0]), .data_out(dob[0]), .rd_miss(mo[0]), .occ_count(oc[0]));

  mem_rw_stage #(.DATA_WIDTH(32), .ADDRESS_WIDTH(4), .READ_LATENCY(2)) dut2 (
    .clk(clk), .rst(rst), .clr(clr), .write_en(we), .read_en(re), .address(addr),
    .data_in(din), .valid_out(vo[1]), .data_out(dob[1]), .rd_miss(mo[1]), .occ_count(oc[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    int          due;
    logic [31:0] d;
    logic        m;
  } exp_t;

  logic [31:0] mmem [16];
  logic        mwr  [16];
  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] last [2];

  function automatic int popcount_written();
    int n = 0;
    for (int i = 0; i < 16; i++) if (mwr[i]) n++;
    return n;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_flush();
    q0.delete();
    q1.delete();
    for (int i = 0; i < 16; i++) mwr[i] = 1'b0;
    last[0] = '0;
    last[1] = '0;
  endtask

  task automatic model_edge(input logic w, input logic r, input logic c,
                            input logic [3:0] a, input logic [31:0] d);
    exp_t e;
    if (r) begin
      e.m = !(w || mwr[a]);
      e.d = w ? d : (mwr[a] ? mmem[a] : 32'h0);
      e.due = cyc;     q0.push_back(e);
      e.due = cyc + 1; q1.push_back(e);
    end
    if (c) for (int i = 0; i < 16; i++) mwr[i] = 1'b0;
    if (w) begin
      mmem[a] = d;
      mwr[a]  = 1'b1;
    end
  endtask

  task automatic model_check();
    for (int i = 0; i < 2; i++) begin
      exp_t e;
      logic hit = 1'b0;
      if (i == 0) begin
        if (q0.size() > 0 && q0[0].due == cyc) begin e = q0.pop_front(); hit = 1'b1; end
      end else begin
        if (q1.size() > 0 && q1[0].due == cyc) begin e = q1.pop_front(); hit = 1'b1; end
      end
      if (hit) begin
        check($sformatf("L%0d valid", i+1), 32'(vo[i]), 32'd1);
        check($sformatf("L%0d data", i+1), dob[i], e.d);
        check($sformatf("L%0d miss", i+1), 32'(mo[i]), 32'(e.m));
        last[i] = e.d;
      end else begin
        check($sformatf("L%0d idle valid", i+1), 32'(vo[i]), 32'd0);
        check($sformatf("L%0d held data", i+1), dob[i], last[i]);
        check($sformatf("L%0d idle miss", i+1), 32'(mo[i]), 32'd0);
      end
      check($sformatf("L%0d occ", i+1), 32'(oc[i]), 32'(popcount_written()));
    end
  endtask

  // One clock: drive inputs, let the edge happen, update model, check.
  task automatic cycle(input logic w, input logic r, input logic c,
                       input logic [3:0] a, input logic [31:0] d);
    we = w; re = r; clr = c; addr = a; din = d;
    @(posedge clk);
    cyc++;
    model_edge(w, r, c, a, d);
    #1;
    model_check();
    we = 1'b0; re = 1'b0; clr = 1'b0;
  endtask

  task automatic do_reset();
    we = 1'b0; re = 1'b0; clr = 1'b0;
    rst = 1'b0;
    model_flush();
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("L%0d reset valid", i+1), 32'(vo[i]), 32'd0);
      check($sformatf("L%0d reset data", i+1), dob[i], 32'd0);
      check($sformatf("L%0d reset miss", i+1), 32'(mo[i]), 32'd0);
      check($sformatf("L%0d reset occ", i+1), 32'(oc[i]), 32'd0);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // ---------------- directed vector table (L1 instance) ----------------
  typedef struct {
    logic        w, r, c;
    logic [3:0]  a;
    logic [31:0] d;
    logic        ev;
    logic [31:0] ed;
    logic        em;
    int          eocc;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int pulses;
    int l2_seen;

    tbl[0] = '{1'b0, 1'b1, 1'b0, 4'd3, 32'h0,        1'b1, 32'h0,        1'b1, 0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 4'd5, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0, 1};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 4'd5, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0, 1};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 4'd0, 32'h0,        1'b0, 32'hDEADBEEF, 1'b0, 1};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 4'd7, 32'hA5A5A5A5, 1'b1, 32'hA5A5A5A5, 1'b0, 2};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 4'd0, 32'h0,        1'b0, 32'hA5A5A5A5, 1'b0, 2};

    rst = 1'b0; we = 1'b0; re = 1'b0; clr = 1'b0; addr = '0; din = '0;
    model_flush();
    #12;
    do_reset();

    for (int i = 0; i < 6; i++) begin
      cycle(tbl[i].w, tbl[i].r, tbl[i].c, tbl[i].a, tbl[i].d);
      check($sformatf("vec%0d valid", i), 32'(vo[0]), 32'(tbl[i].ev));
      check($sformatf("vec%0d data", i), dob[0], tbl[i].ed);
      check($sformatf("vec%0d miss", i), 32'(mo[0]), 32'(tbl[i].em));
      check($sformatf("vec%0d occ", i), 32'(oc[0]), 32'(tbl[i].eocc));
    end

    // Fill every entry, rewrite entry 0: occupancy must stop at 16.
    for (int a = 0; a < 16; a++) cycle(1'b1, 1'b0, 1'b0, 4'(a), 32'(a) * 32'h11111111);
    cycle(1'b1, 1'b0, 1'b0, 4'd0, 32'h12345678);
    check("fill occ", 32'(oc[0]), 32'd16);
    pulses = 0;
    for (int a = 0; a < 16; a++) begin
      cycle(1'b0, 1'b1, 1'b0, 4'(a), 32'h0);
      if (vo[0]) pulses++;
    end
    check("b2b pulses", 32'(pulses), 32'd16);
    check("b2b last data", dob[0], 32'hFFFFFFFF);
    cycle(1'b0, 1'b0, 1'b0, 4'd0, 32'h0);

    // Latency-2 snapshot: write to an in-flight read's address must not leak.
    cycle(1'b1, 1'b0, 1'b0, 4'd2, 32'h1);
    cycle(1'b0, 1'b1, 1'b0, 4'd2, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 4'd2, 32'h2);
    check("L2 snapshot valid", 32'(vo[1]), 32'd1);
    check("L2 snapshot data", dob[1], 32'h1);
    cycle(1'b0, 1'b0, 1'b0, 4'd0, 32'h0);

    // Reset while a latency-2 read is in flight: it must never emerge.
    cycle(1'b0, 1'b1, 1'b0, 4'd4, 32'h0);
    do_reset();
    l2_seen = 0;
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
      if (vo[1]) l2_seen++;
    end
    check("flushed read pulses", 32'(l2_seen), 32'd0);
    check("post-reset occ", 32'(oc[0]), 32'd0);

    // clr + write same edge, then reads of kept and cleared entries.
    cycle(1'b1, 1'b0, 1'b0, 4'd1, 32'h0BADF00D);
    cycle(1'b1, 1'b0, 1'b1, 4'd9, 32'hCAFE0009);
    check("clr+write occ", 32'(oc[0]), 32'd1);
    cycle(1'b0, 1'b1, 1'b0, 4'd9, 32'h0);
    check("read 9 data", dob[0], 32'hCAFE0009);
    check("read 9 miss", 32'(mo[0]), 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 4'd1, 32'h0);
    check("read 1 miss", 32'(mo[0]), 32'd1);
    check("read 1 data", dob[0], 32'd0);

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 19) == 0), 4'($urandom_range(0, 15)), $urandom);
    end
    cycle(1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 4'd0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
